encoder_4x3_prior: RTL and testbench
====================================

Name: encoder_4x3_prior

Overview:
4-input priority encoder with a valid flag. It produces a 2-bit index (x = MSB, y = LSB) of the highest-priority asserted input, plus V indicating at least one input is asserted. Outputs are registered on a single clock with an asynchronous active-low reset. It is used as a small leaf block wherever a one-of-four request must be reduced to an index.

Parameters:
none (fixed 4-input width)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous reset, active-low
D  input  4  request vector; D[3] highest priority, D[0] lowest
x  output  1  index MSB of highest-priority set bit (registered)
y  output  1  index LSB of highest-priority set bit (registered)
V  output  1  valid: 1 when any D bit is 1 (registered)

Behaviour:
- Reset: rst_n low forces x=0, y=0, V=0 immediately, independent of clk. Outputs hold these values while rst_n is low.
- Release: on the first rising clk edge with rst_n high, D is sampled normally. Release is treated as synchronous to clk by the surrounding design.
- Latency: 1 cycle. D is sampled on the rising clk edge, and x/y/V reflect that sample after the edge. D changes between edges have no effect until the next edge.
- Encoding, applied combinationally to D and then registered:
  - D[3]=1 -> x=1, y=1, V=1 (D[2:0] don't care)
  - else D[2]=1 -> x=1, y=0, V=1 (D[1:0] don't care)
  - else D[1]=1 -> x=0, y=1, V=1 (D[0] don't care)
  - else D[0]=1 -> x=0, y=0, V=1
  - D=0000 -> x=0, y=0, V=0
- Index relations: x = D[3] | D[2]; y = D[3] | (~D[2] & D[1]); V = |D.
- No-request case: D=0000 gives x=y=0, the same index as D=0001. Consumers must qualify x/y with V.
- Simultaneous requests: the highest-numbered set bit always wins. No fairness and no memory of previous winners.
- Reset mid-operation: the async clear overrides any pending sample. No state beyond the three output flops.
- X on D: no special handling required; the bench drives only 0/1.

Test Plan:
- Reset: D=1111, rst_n=0 mid-cycle -> x=0, y=0, V=0 immediately without a clk edge; hold rst_n low for 2 edges -> outputs stay 000.
- Exhaustive sweep: rst_n=1, D=0..15 one per clock, with the check one cycle later:
  - 0 -> xyV=000
  - 1 -> 001
  - 2, 3 -> 011
  - 4..7 -> 101
  - 8..15 -> 111
- Priority conflicts:
  - D=1001 -> x=1, y=1, V=1
  - D=0110 -> x=1, y=0, V=1
  - D=0011 -> x=0, y=1, V=1
- Latency/sampling:
  - D=0100 before edge N -> xyV=101 only after edge N.
  - D pulses to 1000 between edges N and N+1 and returns to 0100 before N+1 -> output stays 101.
- Zero vs D0: D=0001 -> xyV=001, then D=0000 -> 000 (V distinguishes them).
- Reset during activity: D=1000 with xyV=111, assert rst_n low -> 000 asynchronously. Release rst_n -> 111 at the next rising edge.

Source files
------------

// File: rtl/encoder_4x3_prior_if.sv
// Request/index bundle for the 4-input priority encoder.
// Ports: D = 4-bit request vector (D[3] highest priority);
//        x/y = index MSB/LSB of the winning request; V = any request present.
// master drives requests and reads the index; slave is the encoder side.
interface encoder_4x3_prior_if;
   logic [3:0] D;
   logic       x;
   logic       y;
   logic       V;

   modport master (
      output D,
      input  x,
      input  y,
      input  V
   );

   modport slave (
      input  D,
      output x,
      output y,
      output V
   );
endinterface : encoder_4x3_prior_if

// File: rtl/encoder_4x3_prior.sv
// Purpose: reduce a 4-bit request vector to the 2-bit index of its highest set bit, plus a valid flag.
// Latency: 1 clk; D sampled on the rising edge, x/y/V registered. Async active-low clear of all outputs.
// Backpressure: none; a new request vector is accepted every cycle.
// Ports: clk, rst_n (plain); bus (encoder_4x3_prior_if.slave) carries D in and x/y/V out.
module encoder_4x3_prior (
   input  logic                 clk,
   input  logic                 rst_n,
   encoder_4x3_prior_if.slave   bus
);

   logic x_nxt;
   logic y_nxt;
   logic v_nxt;

   // Highest-numbered set bit wins; lower bits are don't-care once a
   // higher one is set. D=0000 yields the same index as D=0001, so
   // consumers must qualify x/y with V.
   always_comb begin
      x_nxt = 1'b0;
      y_nxt = 1'b0;
      v_nxt = 1'b0;
      if (bus.D[3]) begin
         x_nxt = 1'b1;
         y_nxt = 1'b1;
         v_nxt = 1'b1;
      end else if (bus.D[2]) begin
         x_nxt = 1'b1;
         v_nxt = 1'b1;
      end else if (bus.D[1]) begin
         y_nxt = 1'b1;
         v_nxt = 1'b1;
      end else if (bus.D[0]) begin
         v_nxt = 1'b1;
      end
   end

   // The three output flops are the only state in the block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.x <= 1'b0;
         bus.y <= 1'b0;
         bus.V <= 1'b0;
      end else begin
         bus.x <= x_nxt;
         bus.y <= y_nxt;
         bus.V <= v_nxt;
      end
   end

endmodule : encoder_4x3_prior

// File: tb/tb_encoder_4x3_prior.sv
// Bench for encoder_4x3_prior: directed scenarios plus random vectors
// checked against a highest-set-bit reference model.
module tb_encoder_4x3_prior;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   encoder_4x3_prior_if bus ();

   encoder_4x3_prior dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: scan from the top bit down; first set bit gives the index.
   function automatic logic [2:0] model_xyv(input logic [3:0] d);
      for (int i = 3; i >= 0; i--) begin
         if (d[i]) return {2'(i), 1'b1};
      end
      return 3'b000;
   endfunction

   function automatic logic [2:0] obs();
      return {bus.x, bus.y, bus.V};
   endfunction

   // Drive D at the falling edge, let the rising edge sample it, look 1 time unit later.
   task automatic apply(input logic [3:0] d);
      @(negedge clk);
      bus.D = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [2:0] got;
      rst_n = 1'b1;
      apply(4'b1111);
      apply(4'b1111);
      got = obs();
      checks++;
      if (got !== 3'b111) begin
         errors++;
         $display("FAIL reset_pre got=%b exp=111", got);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      got = obs();
      checks++;
      if (got !== 3'b000) begin
         errors++;
         $display("FAIL reset_async got=%b exp=000", got);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      got = obs();
      checks++;
      if (got !== 3'b000) begin
         errors++;
         $display("FAIL reset_hold got=%b exp=000", got);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_sweep();
      logic [2:0] got;
      logic [2:0] exp;
      logic [3:0] d;
      for (int i = 0; i < 16; i++) begin
         d = 4'(i);
         apply(d);
         got = obs();
         exp = model_xyv(d);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL sweep D=%b got=%b exp=%b", d, got, exp);
         end
      end
   endtask

   task automatic test_priority();
      logic [3:0] d_tab [3];
      logic [2:0] e_tab [3];
      logic [2:0] got;
      d_tab[0] = 4'b1001; e_tab[0] = 3'b111;
      d_tab[1] = 4'b0110; e_tab[1] = 3'b101;
      d_tab[2] = 4'b0011; e_tab[2] = 3'b011;
      for (int i = 0; i < 3; i++) begin
         apply(d_tab[i]);
         got = obs();
         checks++;
         if (got !== e_tab[i]) begin
            errors++;
            $display("FAIL priority D=%b got=%b exp=%b", d_tab[i], got, e_tab[i]);
         end
      end
   endtask

   task automatic test_latency();
      logic [2:0] got;
      apply(4'b0000);
      @(negedge clk);
      bus.D = 4'b0100;
      #1;
      got = obs();
      checks++;
      if (got !== 3'b000) begin
         errors++;
         $display("FAIL latency_before_edge got=%b exp=000", got);
      end
      @(posedge clk);
      #1;
      got = obs();
      checks++;
      if (got !== 3'b101) begin
         errors++;
         $display("FAIL latency_after_edge got=%b exp=101", got);
      end
      // Glitch to 1000 between edges, back to 0100 before the next edge.
      @(negedge clk);
      bus.D = 4'b1000;
      #1;
      got = obs();
      checks++;
      if (got !== 3'b101) begin
         errors++;
         $display("FAIL latency_glitch_mid got=%b exp=101", got);
      end
      #2;
      bus.D = 4'b0100;
      @(posedge clk);
      #1;
      got = obs();
      checks++;
      if (got !== 3'b101) begin
         errors++;
         $display("FAIL latency_glitch_edge got=%b exp=101", got);
      end
   endtask

   task automatic test_zero_vs_d0();
      logic [2:0] got;
      apply(4'b0001);
      got = obs();
      checks++;
      if (got !== 3'b001) begin
         errors++;
         $display("FAIL d0_only got=%b exp=001", got);
      end
      apply(4'b0000);
      got = obs();
      checks++;
      if (got !== 3'b000) begin
         errors++;
         $display("FAIL zero got=%b exp=000", got);
      end
   endtask

   task automatic test_reset_active();
      logic [2:0] got;
      apply(4'b1000);
      got = obs();
      checks++;
      if (got !== 3'b111) begin
         errors++;
         $display("FAIL rst_active_pre got=%b exp=111", got);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      got = obs();
      checks++;
      if (got !== 3'b000) begin
         errors++;
         $display("FAIL rst_active_async got=%b exp=000", got);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      got = obs();
      checks++;
      if (got !== 3'b000) begin
         errors++;
         $display("FAIL rst_release_before_edge got=%b exp=000", got);
      end
      @(posedge clk);
      #1;
      got = obs();
      checks++;
      if (got !== 3'b111) begin
         errors++;
         $display("FAIL rst_release_edge got=%b exp=111", got);
      end
   endtask

   task automatic test_random();
      logic [3:0] d;
      logic [2:0] got;
      logic [2:0] exp;
      for (int n = 0; n < 200; n++) begin
         d = 4'($urandom_range(0, 15));
         apply(d);
         got = obs();
         exp = model_xyv(d);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL random n=%0d D=%b got=%b exp=%b", n, d, got, exp);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b1;
      bus.D  = 4'b0000;
      test_reset();
      test_sweep();
      test_priority();
      test_latency();
      test_zero_vs_d0();
      test_reset_active();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_encoder_4x3_prior
